// File: rtl/reaction_timer_datapath.sv
// Timing datapath for the reaction game: pseudo-random red-light delay and
// millisecond reaction counter with last/best score registers.
module reaction_timer_datapath #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 12,
  parameter int unsigned MAX_SCORE    = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        iReset,
  input  logic        startDownCount,
  input  logic        startUpCount,
  input  logic        loadScore,
  output logic        downCountComplete,
  output logic [13:0] score,
  output logic        scoreValid,
  output logic [13:0] bestScore
);

  localparam int unsigned PRE_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [15:0] RAND_MASK = 16'((32'd1 << RAND_BITS) - 32'd1);
  localparam logic [15:0] DELAY_MIN = 16'(MIN_DELAY_MS);
  localparam logic [13:0] SCORE_MAX = 14'(MAX_SCORE);

  logic [15:0]      lfsr;
  logic             lfsrFb;
  logic [PRE_W-1:0] prescaler;
  logic             tick;
  logic [15:0]      downCnt;
  logic [15:0]      delayLoad;
  logic             downActive;
  logic [13:0]      upCnt;
  logic [13:0]      upNext;
  logic             upArmed;
  logic             anyStart;

  assign lfsrFb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign tick      = (prescaler == PRE_LAST);
  assign anyStart  = startDownCount | startUpCount;
  assign delayLoad = DELAY_MIN + (lfsr & RAND_MASK);
  assign upNext    = (upCnt >= SCORE_MAX) ? SCORE_MAX : upCnt + 14'd1;

  // Free-running Fibonacci LFSR; a non-zero seed keeps it out of the all-zero state.
  always_ff @(posedge clk) begin
    if (iReset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsrFb};
    end
  end

  // Millisecond prescaler, realigned by either start strobe.
  always_ff @(posedge clk) begin
    if (iReset) begin
      prescaler <= '0;
    end else if (anyStart || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  // Red-light delay; reload dominates a coincident tick.
  always_ff @(posedge clk) begin
    if (iReset) begin
      downCnt           <= '0;
      downActive        <= 1'b0;
      downCountComplete <= 1'b0;
    end else if (startDownCount) begin
      downCnt           <= delayLoad;
      downActive        <= 1'b1;
      downCountComplete <= 1'b0;
    end else if (downActive && tick) begin
      if (downCnt == 16'd1) begin
        downCnt           <= '0;
        downActive        <= 1'b0;
        downCountComplete <= 1'b1;
      end else begin
        downCnt <= downCnt - 16'd1;
      end
    end
  end

  // Reaction counter and score latching; arming beats a coincident latch request.
  always_ff @(posedge clk) begin
    if (iReset) begin
      upCnt      <= '0;
      upArmed    <= 1'b0;
      score      <= '0;
      scoreValid <= 1'b0;
      bestScore  <= SCORE_MAX;
    end else if (startUpCount) begin
      upCnt   <= '0;
      upArmed <= 1'b1;
    end else if (loadScore && upArmed) begin
      score      <= upCnt;
      scoreValid <= 1'b1;
      upArmed    <= 1'b0;
      if (upCnt < bestScore) begin
        bestScore <= upCnt;
      end
    end else if (upArmed && tick) begin
      upCnt <= upNext;
    end
  end

endmodule

// File: tb/tb_reaction_timer_datapath.sv
// Scoreboard bench: a cycle-level reference model predicts every output of two
// instances (default and tiny saturation value) under directed and random stimulus.
module tb_reaction_timer_datapath;

  localparam int TD    = 4;
  localparam int MIN_D = 3;
  localparam int RBITS = 2;
  localparam int RMASK = (1 << RBITS) - 1;

  typedef struct packed {
    logic        dcc;
    logic [13:0] score;
    logic        valid;
    logic [13:0] best;
  } outs_t;

  logic clk = 1'b0;
  logic iReset, startDownCount, startUpCount, loadScore;
  logic dcc0, valid0, dcc1, valid1;
  logic [13:0] score0, best0, score1, best1;

  always #5 clk = ~clk;

  reaction_timer_datapath #(.TICK_DIV(TD), .MIN_DELAY_MS(MIN_D), .RAND_BITS(RBITS),
                            .MAX_SCORE(9999), .LFSR_SEED(16'hACE1)) dut0 (
    .clk(clk), .iReset(iReset), .startDownCount(startDownCount),
    .startUpCount(startUpCount), .loadScore(loadScore),
    .downCountComplete(dcc0), .score(score0), .scoreValid(valid0), .bestScore(best0));

  reaction_timer_datapath #(.TICK_DIV(TD), .MIN_DELAY_MS(MIN_D), .RAND_BITS(RBITS),
                            .MAX_SCORE(7), .LFSR_SEED(16'hACE1)) dut1 (
    .clk(clk), .iReset(iReset), .startDownCount(startDownCount),
    .startUpCount(startUpCount), .loadScore(loadScore),
    .downCountComplete(dcc1), .score(score1), .scoreValid(valid1), .bestScore(best1));

  int errors = 0;
  int checks = 0;

  // Reference model state, one slot per instance
  logic [15:0] mLfsr [2];
  int mPre [2], mRem [2], mUp [2], mScore [2], mBest [2];
  bit mAct [2], mDone [2], mArmed [2], mValid [2];
  int mMax [2] = '{9999, 7};
  int lastD;

  outs_t q0[$];
  outs_t q1[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic stepModel(input int i, input bit r, input bit sd, input bit su, input bit ld);
    bit tk;
    if (r) begin
      mLfsr[i] = 16'hACE1; mPre[i] = 0; mRem[i] = 0; mAct[i] = 0; mDone[i] = 0;
      mUp[i] = 0; mArmed[i] = 0; mScore[i] = 0; mValid[i] = 0; mBest[i] = mMax[i];
    end else begin
      tk = (mPre[i] == TD - 1);
      if (sd) begin
        mRem[i] = MIN_D + int'(mLfsr[i] & 16'(RMASK)); mAct[i] = 1; mDone[i] = 0;
      end else if (mAct[i] && tk) begin
        mRem[i] = mRem[i] - 1;
        if (mRem[i] == 0) begin mAct[i] = 0; mDone[i] = 1; end
      end
      if (su) begin
        mUp[i] = 0; mArmed[i] = 1;
      end else if (ld && mArmed[i]) begin
        mScore[i] = mUp[i]; mValid[i] = 1; mArmed[i] = 0;
        if (mUp[i] < mBest[i]) mBest[i] = mUp[i];
      end else if (mArmed[i] && tk && mUp[i] < mMax[i]) begin
        mUp[i] = mUp[i] + 1;
      end
      mPre[i]  = (sd || su || tk) ? 0 : mPre[i] + 1;
      mLfsr[i] = {mLfsr[i][14:0], ^(mLfsr[i] & 16'hB400)};
    end
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic cyc(input bit r, input bit sd, input bit su, input bit ld);
    outs_t e;
    iReset = r; startDownCount = sd; startUpCount = su; loadScore = ld;
    if (sd && !r) lastD = MIN_D + int'(mLfsr[0] & 16'(RMASK));
    for (int i = 0; i < 2; i++) begin
      stepModel(i, r, sd, su, ld);
      e.dcc = mDone[i]; e.score = 14'(mScore[i]); e.valid = mValid[i]; e.best = 14'(mBest[i]);
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int w);
    cyc(0, 0, 1, 0);
    repeat (w) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
  endtask

  // Monitor: outputs are compared against the queued prediction on every falling edge
  always @(negedge clk) begin
    outs_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checks++;
      if ({dcc0, score0, valid0, best0} !== e) begin
        errors++;
        $display("FAIL sb0 @%0t: got dcc=%0b score=%0d valid=%0b best=%0d expected dcc=%0b score=%0d valid=%0b best=%0d",
                 $time, dcc0, score0, valid0, best0, e.dcc, e.score, e.valid, e.best);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checks++;
      if ({dcc1, score1, valid1, best1} !== e) begin
        errors++;
        $display("FAIL sb1 @%0t: got dcc=%0b score=%0d valid=%0b best=%0d expected dcc=%0b score=%0d valid=%0b best=%0d",
                 $time, dcc1, score1, valid1, best1, e.dcc, e.score, e.valid, e.best);
      end
    end
  end

  initial begin
    int n, hits;
    bit hit;
    lastD = 0;

    // Reset values
    cyc(1, 0, 0, 0);
    chk("rst_lfsr", int'(dut0.lfsr), 16'hACE1);
    chk("rst_dcc", int'(dcc0), 0);
    chk("rst_score", int'(score0), 0);
    chk("rst_valid", int'(valid0), 0);
    chk("rst_best", int'(best0), 9999);
    chk("rst_best_small", int'(best1), 7);

    // Red-light delay timing
    repeat (3) cyc(0, 1, 0, 0);
    chk("delay_load", int'(dut0.downCnt), lastD);
    n = 0;
    while (dcc0 !== 1'b1 && n < 200) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("delay_rise", n, 4 * lastD);
    chk("delay_range", int'((n % 4 == 0) && (n / 4 >= 3) && (n / 4 <= 6)), 1);

    // Reaction scores and best tracking
    run(40);
    chk("run1_score", int'(score0), 10);
    chk("run1_valid", int'(valid0), 1);
    chk("run1_best", int'(best0), 10);
    chk("run1_sat", int'(score1), 7);
    run(20);
    chk("run2_score", int'(score0), 5);
    chk("run2_best", int'(best0), 5);
    run(60);
    chk("run3_score", int'(score0), 15);
    chk("run3_best", int'(best0), 5);
    run(100);
    chk("run4_sat", int'(score1), 7);
    chk("run4_score", int'(score0), 25);

    // Latch requests that must be ignored
    cyc(0, 0, 0, 1);
    chk("unarmed_score", int'(score0), 25);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("noarm_valid", int'(valid0), 0);
    chk("noarm_score", int'(score0), 0);
    cyc(0, 0, 1, 1);
    chk("coinc_upcnt", int'(dut0.upCnt), 0);
    chk("coinc_armed", int'(dut0.upArmed), 1);
    chk("coinc_valid", int'(valid0), 0);
    repeat (8) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("after_coinc_score", int'(score0), 2);

    // Reset in the middle of a delay
    for (int k = 0; k < 32; k++) begin
      cyc(0, 1, 0, 0);
      if (lastD >= 4) break;
    end
    hit = 0;
    for (int k = 0; k < 40; k++) begin
      if (dut0.downCnt == 16'd4) begin hit = 1; break; end
      cyc(0, 0, 0, 0);
    end
    chk("cnt4_reached", int'(hit), 1);
    cyc(1, 0, 0, 0);
    hits = 0;
    repeat (80) begin
      cyc(0, 0, 0, 0);
      if (dcc0 === 1'b1) hits++;
    end
    chk("no_rise_after_reset", hits, 0);
    cyc(0, 1, 0, 0);
    n = 0;
    while (dcc0 !== 1'b1 && n < 60) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("second_delay_rise", int'(dcc0), 1);
    cyc(0, 1, 0, 0);
    chk("dcc_cleared", int'(dcc0), 0);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 999) == 0), ($urandom_range(0, 199) == 0),
          ($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0));
    end
    cyc(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
